// File: rtl/moore_seq_n_det_pkg.sv
// Shared types and helpers for the programmable Moore sequence detector.
package moore_seq_pkg;

  // FILL: not enough bits held yet; ARMED: enough bits, last sample missed;
  // HIT: last accepted sample completed the pattern.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_e;

  // Width needed to hold a length in 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Zero-length patterns become 1; over-long patterns are cut to pat_w.
  function automatic int clamp_len(input int len, input int pat_w);
    if (len == 0)     return 1;
    if (len > pat_w)  return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/moore_seq_n_det_if.sv
// Stream, control and status bundle of the sequence detector.
interface moore_seq_n_det_if
  import moore_seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = len_w(PAT_W)
);
  logic             x_vld;
  logic             x;
  logic             ovl;
  logic             pat_ld;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] pat_len_in;
  logic             cnt_clr;
  logic             y;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output x_vld, x, ovl, pat_ld, pat_in, pat_len_in, cnt_clr,
    input  y, armed, match_cnt
  );

  modport slave (
    input  x_vld, x, ovl, pat_ld, pat_in, pat_len_in, cnt_clr,
    output y, armed, match_cnt
  );
endinterface

// File: rtl/moore_seq_n_det_hist.sv
// Bit history shift register and saturating fill counter.
// Exposes the post-shift values so the compare can look at the bit being
// sampled this cycle.
module moore_seq_hist
  import moore_seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             ld_i,      // pattern reload: wipe history
  input  logic             smp_i,     // accepted stream bit this cycle
  input  logic             x_i,
  input  logic             fclr_i,    // non-overlap hit: restart fill
  output logic [PAT_W-1:0] hist_d_o,  // history after shifting in x_i
  output logic [LEN_W-1:0] fill_d_o,  // fill after counting x_i
  output logic [LEN_W-1:0] fill_q_o
);

  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;

  // Candidate next values for an accepted sample.
  always_comb begin
    hist_d_o = {hist_q[PAT_W-2:0], x_i};
    fill_d_o = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
  end

  // Reset and reload both clear; otherwise advance only on accepted bits.
  always_ff @(posedge clk) begin
    if (rst_b || ld_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (smp_i) begin
      hist_q <= hist_d_o;
      fill_q <= fclr_i ? '0 : fill_d_o;
    end
  end

  assign fill_q_o = fill_q;

endmodule

// File: rtl/moore_seq_n_det.sv
// Programmable Moore sequence detector: compare, FSM and match counter.
// y is decoded from state, so it rises one edge after the final bit.
module moore_seq_n_det
  import moore_seq_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter int             CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b0011),
  parameter int             RST_LEN = 2,
  localparam int            LEN_W   = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_b,
  moore_seq_n_det_if.slave bus
);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  logic [PAT_W-1:0] hist_d;
  logic [LEN_W-1:0] fill_d, fill_q;
  logic             smp, eq, match;
  logic [LEN_W-1:0] len_ld;

  // A reload cycle swallows the stream bit.
  assign smp    = bus.x_vld & ~bus.pat_ld;
  assign len_ld = LEN_W'(clamp_len(int'(bus.pat_len_in), PAT_W));

  moore_seq_hist #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_hist (
    .clk      (clk),
    .rst_b    (rst_b),
    .ld_i     (bus.pat_ld),
    .smp_i    (smp),
    .x_i      (bus.x),
    .fclr_i   (match & ~bus.ovl),
    .hist_d_o (hist_d),
    .fill_d_o (fill_d),
    .fill_q_o (fill_q)
  );

  // Compare the low len bits of the shifted history with the pattern.
  always_comb begin
    eq = 1'b1;
    for (int i = 0; i < PAT_W; i++)
      if (LEN_W'(i) < len_q && hist_d[i] != pat_q[i]) eq = 1'b0;
  end

  assign match = smp & eq & (fill_d >= len_q);

  // Pattern and length registers.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      pat_q <= RST_PAT;
      len_q <= LEN_W'(RST_LEN);
    end else if (bus.pat_ld) begin
      pat_q <= bus.pat_in;
      len_q <= len_ld;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_b) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next state: a hit with no new bit falls back according to the fill left
  // behind, which is zero after a non-overlapping match.
  always_comb begin
    state_d = state_q;
    if (bus.pat_ld)
      state_d = FILL;
    else if (smp) begin
      if (match)                 state_d = HIT;
      else if (fill_d >= len_q)  state_d = ARMED;
      else                       state_d = FILL;
    end else if (state_q == HIT)
      state_d = (fill_q >= len_q) ? ARMED : FILL;
  end

  // Saturating match counter; clear beats a coincident match.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr)                 cnt_d = '0;
    else if (match && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  // Match counter register.
  always_ff @(posedge clk) begin
    if (rst_b) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.y         = (state_q == HIT);
  assign bus.armed     = (state_q != FILL);
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_moore_seq_n_det.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs, popped and compared one tick after the following clock edge.
module tb_moore_seq_n_det;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int LEN_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic       y;
    logic       armed;
    logic [1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  moore_seq_n_det_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  moore_seq_n_det #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state
  int m_hist, m_fill, m_len, m_pat, m_st, m_cnt;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit xb, input bit ov,
                            input bit ld, input int p, input int l, input bit clr);
    int nh, nf;
    bit m;
    m = 0;
    if (r) begin
      m_pat = 3; m_len = 2; m_hist = 0; m_fill = 0; m_st = 0; m_cnt = 0;
      return;
    end
    if (ld) begin
      m_pat  = p;
      m_len  = (l == 0) ? 1 : (l > PAT_W ? PAT_W : l);
      m_hist = 0; m_fill = 0; m_st = 0;
    end else if (v) begin
      nh = ((m_hist << 1) | xb) & 'hF;
      nf = (m_fill + 1 > PAT_W) ? PAT_W : m_fill + 1;
      m  = (((nh ^ m_pat) & ((1 << m_len) - 1)) == 0) && (nf >= m_len);
      m_hist = nh;
      m_fill = (m && !ov) ? 0 : nf;
      m_st   = m ? 2 : (nf >= m_len ? 1 : 0);
    end else if (m_st == 2) begin
      m_st = (m_fill >= m_len) ? 1 : 0;
    end
    if (clr)                    m_cnt = 0;
    else if (m && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic cyc(input bit r, input bit v, input bit xb, input bit ov,
                     input bit ld, input int p, input int l, input bit clr);
    exp_t e;
    @(negedge clk);
    rst_b          = r;
    bus.x_vld      = v;
    bus.x          = xb;
    bus.ovl        = ov;
    bus.pat_ld     = ld;
    bus.pat_in     = PAT_W'(p);
    bus.pat_len_in = LEN_W'(l);
    bus.cnt_clr    = clr;
    model_step(r, v, xb, ov, ld, p, l, clr);
    e.y     = (m_st == 2);
    e.armed = (m_st != 0);
    e.cnt   = 2'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("y",     int'(bus.y),         int'(e.y));
    chk("armed", int'(bus.armed),     int'(e.armed));
    chk("cnt",   int'(bus.match_cnt), int'(e.cnt));
  endtask

  task automatic bit_in(input bit v, input bit xb, input bit ov);
    cyc(0, v, xb, ov, 0, 0, 0, 0);
  endtask

  task automatic reset1();
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic load(input int p, input int l);
    cyc(0, 1, 1, 1, 1, p, l, 0);
  endtask

  initial begin
    bit s6 [6] = '{0, 1, 0, 1, 1, 1};
    bit s7 [7] = '{1, 0, 1, 1, 0, 1, 1};

    rst_b = 1'b1;
    bus.x_vld = 0; bus.x = 0; bus.ovl = 1; bus.pat_ld = 0;
    bus.pat_in = '0; bus.pat_len_in = '0; bus.cnt_clr = 0;

    // Reset state (also asserts pat_ld/cnt_clr to show reset wins)
    reset1();
    cyc(1, 1, 1, 1, 1, 'hF, 1, 1);

    // Default "11", overlapping
    foreach (s6[i]) bit_in(1, s6[i], 1);
    bit_in(0, 0, 1);

    // Same stream, non-overlapping
    reset1();
    foreach (s6[i]) bit_in(1, s6[i], 0);
    bit_in(0, 0, 0);

    // "1011" len 4 with gaps, overlapping
    load('b1011, 4);
    for (int i = 0; i < 7; i++) begin
      bit_in(1, s7[i], 1);
      if (i == 0 || i == 3 || i == 5) bit_in(0, 1, 1);
    end
    bit_in(0, 0, 1);

    // Length clamps: 0 -> 1, 7 -> 4
    cyc(0, 0, 0, 1, 1, 'b0001, 0, 1);
    for (int i = 0; i < 3; i++) bit_in(1, 1, 1);
    load('b1111, 7);
    for (int i = 0; i < 5; i++) bit_in(1, 1, 1);

    // Saturation at 3, then clear coincident with a match
    cyc(0, 0, 0, 1, 1, 'b0001, 1, 1);
    for (int i = 0; i < 5; i++) bit_in(1, 1, 1);
    cyc(0, 1, 1, 1, 0, 0, 0, 1);
    bit_in(1, 1, 1);

    // Reset mid-stream with a pending match bit
    reset1();
    bit_in(1, 0, 1);
    bit_in(1, 1, 1);
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    bit_in(1, 1, 1);
    bit_in(1, 1, 1);

    // Random stream on "101", mixed modes and gaps
    load('b101, 3);
    for (int i = 0; i < 80; i++)
      cyc(0, ($urandom % 4) != 0, $urandom % 2, $urandom % 2, 0, 0, 0,
          ($urandom % 16) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
